// File: rtl/serial_subtractor_4bit_pkg.sv
// Shared types for the bit-serial subtractor: the controller state encoding.
package serial_subtractor_4bit_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_4bit_full_adder.sv
// Single full-adder cell; reused once per cycle as the serial slice.
module serial_subtractor_4bit_full_adder (
  input  logic i_A,
  input  logic i_B,
  input  logic i_Cin,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_A ^ i_B ^ i_Cin;
  assign o_carry = (i_A & i_B) | (i_A & i_Cin) | (i_B & i_Cin);

endmodule

// File: rtl/serial_subtractor_4bit.sv
// Bit-serial A-B: one full-adder slice walks A + ~B + 1 LSB-first over WIDTH cycles,
// result delivered with a start/valid handshake.
module serial_subtractor_4bit
  import serial_subtractor_4bit_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_overflow,
  output logic             o_busy,
  output logic             o_valid
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] res_next;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             a_msb;
  logic             b_msb;
  logic             sum_bit;
  logic             carry_out;
  logic             last;

  serial_subtractor_4bit_full_adder u_slice (
    .i_A     (sh_a[0]),
    .i_B     (sh_b[0]),
    .i_Cin   (carry),
    .o_sum   (sum_bit),
    .o_carry (carry_out)
  );

  // res keeps the WIDTH-1 most recent sum bits; the new bit enters at the MSB
  assign res_next = {sum_bit, res};
  assign last     = (cnt == LAST_CNT);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = i_start ? SHIFT : IDLE;
      SHIFT:   state_next = last ? DONE : SHIFT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_a       <= '0;
      sh_b       <= '0;
      res        <= '0;
      cnt        <= '0;
      carry      <= 1'b0;
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      o_diff     <= '0;
      o_borrow   <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            sh_a  <= i_A;
            sh_b  <= ~i_B;
            carry <= 1'b1;
            cnt   <= '0;
            a_msb <= i_A[WIDTH-1];
            b_msb <= i_B[WIDTH-1];
          end
        end
        SHIFT: begin
          res   <= res_next[WIDTH-1:1];
          sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
          carry <= carry_out;
          cnt   <= cnt + CNT_W'(1);
          // Final slice: its sum bit is the result MSB, its carry-out the inverted borrow
          if (last) begin
            o_diff     <= res_next;
            o_borrow   <= ~carry_out;
            o_overflow <= (a_msb != b_msb) && (sum_bit != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy  = (state != IDLE);
  assign o_valid = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Scoreboard bench: stimulus pushes expected results, a negedge monitor pops on o_valid.
module tb_serial_subtractor_4bit;

  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    int               cyc;
  } exp_t;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic             i_start = 1'b0;
  logic [WIDTH-1:0] i_A = '0;
  logic [WIDTH-1:0] i_B = '0;
  logic [WIDTH-1:0] o_diff;
  logic             o_borrow;
  logic             o_overflow;
  logic             o_busy;
  logic             o_valid;

  exp_t sbq[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;

  serial_subtractor_4bit #(.WIDTH(WIDTH)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_A        (i_A),
    .i_B        (i_B),
    .o_diff     (o_diff),
    .o_borrow   (o_borrow),
    .o_overflow (o_overflow),
    .o_busy     (o_busy),
    .o_valid    (o_valid)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: plain integer arithmetic on unsigned and signed views
  function automatic exp_t refModel(input int a, input int b, input int validCyc);
    exp_t e;
    int sa, sb, d;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    d = sa - sb;
    e.diff   = WIDTH'((a - b + 16) % 16);
    e.borrow = (a < b);
    e.ovf    = (d > 7) || (d < -8);
    e.cyc    = validCyc;
    return e;
  endfunction

  task automatic applyStimulus(input int a, input int b, input bit track);
    int guard = 0;
    @(negedge i_clk);
    while (o_busy && guard < 50) begin
      guard++;
      @(negedge i_clk);
    end
    if (guard >= 50) checkOutput("idle_timeout", 1, 0);
    i_A = WIDTH'(a);
    i_B = WIDTH'(b);
    i_start = 1'b1;
    if (track) sbq.push_back(refModel(a, b, cyc + 5));
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    i_A = WIDTH'($urandom);
    i_B = WIDTH'($urandom);
  endtask

  task automatic waitDrain();
    int guard = 0;
    @(negedge i_clk);
    while ((sbq.size() != 0 || o_busy) && guard < 200) begin
      guard++;
      @(negedge i_clk);
    end
    if (guard >= 200) checkOutput("drain_timeout", sbq.size(), 0);
  endtask

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (sbq.size() != 0 && cyc >= sbq[0].cyc - 4 && !o_busy)
        checkOutput("busy_gap", o_busy, 1);
      if (o_valid) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          checkOutput("latency", cyc, e.cyc);
          checkOutput("diff", o_diff, e.diff);
          checkOutput("borrow", o_borrow, e.borrow);
          checkOutput("overflow", o_overflow, e.ovf);
          checkOutput("busy_with_valid", o_busy, 1);
        end
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("reset_diff", o_diff, 0);
    checkOutput("reset_borrow", o_borrow, 0);
    checkOutput("reset_overflow", o_overflow, 0);
    checkOutput("reset_busy", o_busy, 0);
    checkOutput("reset_valid", o_valid, 0);

    applyStimulus(9, 3, 1'b1);
    waitDrain();
    applyStimulus(3, 9, 1'b1);
    waitDrain();
    applyStimulus(5, 5, 1'b1);
    waitDrain();
    applyStimulus(0, 1, 1'b1);
    waitDrain();

    // Starts during SHIFT and DONE must be ignored and operand changes have no effect
    applyStimulus(8, 1, 1'b1);
    i_start = 1'b1;
    i_A = 4'd3;
    i_B = 4'd9;
    repeat (5) @(posedge i_clk);
    #1;
    i_start = 1'b0;
    waitDrain();
    repeat (8) @(negedge i_clk);

    // Abort in the second SHIFT cycle: no result, everything back to reset values
    applyStimulus(12, 4, 1'b0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("abort_diff", o_diff, 0);
    checkOutput("abort_borrow", o_borrow, 0);
    checkOutput("abort_overflow", o_overflow, 0);
    checkOutput("abort_busy", o_busy, 0);
    checkOutput("abort_valid", o_valid, 0);
    repeat (8) @(negedge i_clk);
    applyStimulus(12, 4, 1'b1);
    waitDrain();

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        applyStimulus(a, b, 1'b1);
    waitDrain();

    for (int n = 0; n < 100; n++) begin
      applyStimulus(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), 1'b1);
      repeat ($urandom_range(3, 0)) @(negedge i_clk);
    end
    waitDrain();
    repeat (4) @(negedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
